// File: rtl/ascon_init_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : ascon_init_sched_if
// Description : Requester, configuration and core-side signal bundle for the
//               Ascon permutation job scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface ascon_init_sched_if;
    logic [1:0]          req_valid_i;
    logic [1:0][319:0]   req_state_i;
    logic [1:0]          req_ready_o;
    logic [1:0]          rsp_valid_o;
    logic [1:0]          rsp_ready_i;
    logic [319:0]        rsp_state_o;
    logic                rsp_err_o;
    logic                cfg_valid_i;
    logic [4:0]          cfg_addr_i;
    logic [19:0]         cfg_data_i;
    logic                cfg_ready_o;
    logic                core_start_o;
    logic [319:0]        core_state_o;
    logic                core_upd_sbox_o;
    logic [4:0]          core_sbox_addr_o;
    logic [19:0]         core_sbox_data_o;
    logic                core_busy_i;
    logic                core_intr_i;
    logic [319:0]        core_state_i;
    logic [15:0]         done_cnt_o;

    modport slave (
        input  req_valid_i, req_state_i, rsp_ready_i,
        input  cfg_valid_i, cfg_addr_i, cfg_data_i,
        input  core_busy_i, core_intr_i, core_state_i,
        output req_ready_o, rsp_valid_o, rsp_state_o, rsp_err_o, cfg_ready_o,
        output core_start_o, core_state_o, core_upd_sbox_o,
        output core_sbox_addr_o, core_sbox_data_o, done_cnt_o
    );

    modport master (
        output req_valid_i, req_state_i, rsp_ready_i,
        output cfg_valid_i, cfg_addr_i, cfg_data_i,
        output core_busy_i, core_intr_i, core_state_i,
        input  req_ready_o, rsp_valid_o, rsp_state_o, rsp_err_o, cfg_ready_o,
        input  core_start_o, core_state_o, core_upd_sbox_o,
        input  core_sbox_addr_o, core_sbox_data_o, done_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/ascon_init_sched.sv
`default_nettype none
// ============================================================================
// Module      : ascon_init_sched
// Description : Arbitrates two requesters onto one Ascon permutation core,
//               forwards S-box table writes and guards jobs with a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_init_sched #(
    parameter int TIMEOUT = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    ascon_init_sched_if.slave  bus
);

    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_rr;
    logic                 r_grant;
    logic [c_cnt_w-1:0]   r_tmo_cnt;
    logic                 r_core_start;
    logic [319:0]         r_core_state;
    logic                 r_upd_sbox;
    logic [4:0]           r_sbox_addr;
    logic [19:0]          r_sbox_data;
    logic [1:0]           r_rsp_valid;
    logic [319:0]         r_rsp_state;
    logic                 r_rsp_err;
    logic [15:0]          r_done_cnt;

    logic                 w_cfg_ready;
    logic [1:0]           w_req_ready;
    logic                 w_gnt_idx;
    logic                 w_cfg_fire;
    logic                 w_req_fire;
    logic                 w_intr_fire;
    logic                 w_tmo_fire;
    logic                 w_rsp_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cfg_ready  = 1'b0;
        w_req_ready  = 2'b00;
        w_gnt_idx    = r_rr;
        w_cfg_fire   = 1'b0;
        w_req_fire   = 1'b0;
        w_intr_fire  = 1'b0;
        w_tmo_fire   = 1'b0;
        w_rsp_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cfg_ready = 1'b1;
                // Table writes pre-empt jobs; a busy core blocks new grants.
                if (bus.cfg_valid_i) begin
                    w_cfg_fire = 1'b1;
                end else if (!bus.core_busy_i && (bus.req_valid_i != 2'b00)) begin
                    w_gnt_idx    = (bus.req_valid_i == 2'b11) ? r_rr : bus.req_valid_i[1];
                    w_req_ready  = w_gnt_idx ? 2'b10 : 2'b01;
                    w_req_fire   = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_intr_i) begin
                    w_intr_fire  = 1'b1;
                    w_state_next = S_RESP;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_tmo_fire   = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i[r_grant]) begin
                    w_rsp_fire   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr         <= 1'b0;
            r_grant      <= 1'b0;
            r_tmo_cnt    <= '0;
            r_core_start <= 1'b0;
            r_core_state <= '0;
            r_upd_sbox   <= 1'b0;
            r_sbox_addr  <= '0;
            r_sbox_data  <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_state  <= '0;
            r_rsp_err    <= 1'b0;
            r_done_cnt   <= '0;
        end else begin
            r_core_start <= w_req_fire;
            r_upd_sbox   <= w_cfg_fire;
            if (w_cfg_fire) begin
                r_sbox_addr <= bus.cfg_addr_i;
                r_sbox_data <= bus.cfg_data_i;
            end
            if (w_req_fire) begin
                r_core_state <= bus.req_state_i[w_gnt_idx];
                r_grant      <= w_gnt_idx;
            end
            if (r_state == S_START) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            // A done pulse coinciding with the timeout still counts as success.
            if (w_intr_fire) begin
                r_rsp_state <= bus.core_state_i;
                r_rsp_err   <= 1'b0;
                r_done_cnt  <= r_done_cnt + 16'd1;
                r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
            end else if (w_tmo_fire) begin
                r_rsp_state <= '0;
                r_rsp_err   <= 1'b1;
                r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
            end
            if (w_rsp_fire) begin
                r_rsp_valid <= 2'b00;
                r_rr        <= ~r_grant;
            end
        end
    end

    assign bus.req_ready_o      = w_req_ready;
    assign bus.cfg_ready_o      = w_cfg_ready;
    assign bus.rsp_valid_o      = r_rsp_valid;
    assign bus.rsp_state_o      = r_rsp_state;
    assign bus.rsp_err_o        = r_rsp_err;
    assign bus.core_start_o     = r_core_start;
    assign bus.core_state_o     = r_core_state;
    assign bus.core_upd_sbox_o  = r_upd_sbox;
    assign bus.core_sbox_addr_o = r_sbox_addr;
    assign bus.core_sbox_data_o = r_sbox_data;
    assign bus.done_cnt_o       = r_done_cnt;

endmodule
`default_nettype wire
